// File: rtl/sparse_frame_decoder.sv
// Serial frame to sparse address stream converter with a one-frame hold buffer.
// Optional macro SPARSE_DECODER_COUNT_EN adds the frame_count popcount output.
module sparse_frame_decoder #(
    parameter int SIZE = 8,
    localparam int ADDR_W = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int CNT_W  = $clog2(SIZE + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              addr_last,
`ifdef SPARSE_DECODER_COUNT_EN
    output logic [CNT_W-1:0]  frame_count,
`endif
    output logic              empty_frame,
    output logic              overflow
);

    typedef enum logic {IDLE, RECV} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]   shift_q, shift_d;
    logic [SIZE-1:0]   hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;

    logic              accept, complete, pop, hold_free, load;
    logic [ADDR_W-1:0] idx;
    logic [SIZE-1:0]   frame_w;
    logic [SIZE-1:0]   hold_rest;

    // Lowest set bit of hold; addresses are emitted in ascending order.
    always_comb begin
        addr_out = '0;
        for (int i = SIZE - 1; i >= 0; i--)
            if (hold_q[i]) addr_out = ADDR_W'(i);
    end

    assign hold_rest  = hold_q & (hold_q - SIZE'(1));
    assign addr_valid = hold_full_q;
    assign addr_last  = (hold_q != '0) && (hold_rest == '0);
    assign pop        = hold_full_q & addr_ready;
    assign hold_free  = !hold_full_q || (pop && addr_last);

    assign accept   = bit_valid & (frame_start | (state_q == RECV));
    assign idx      = frame_start ? '0 : cnt_q;
    assign complete = accept && (idx == ADDR_W'(SIZE - 1));

    // A restart discards the partial frame, so the new bit lands on a clean map.
    always_comb begin
        frame_w      = frame_start ? '0 : shift_q;
        frame_w[idx] = bit_in;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (accept) begin
            if (complete) begin
                state_d = IDLE;
                cnt_d   = '0;
                shift_d = '0;
            end else begin
                state_d = RECV;
                cnt_d   = idx + ADDR_W'(1);
                shift_d = frame_w;
            end
        end
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        empty_d     = 1'b0;
        ovf_d       = 1'b0;
        load        = 1'b0;
        if (pop) begin
            hold_d = hold_rest;
            if (addr_last) hold_full_d = 1'b0;
        end
        if (complete) begin
            if (frame_w == '0) begin
                empty_d = 1'b1;
            end else if (hold_free) begin
                load        = 1'b1;
                hold_d      = frame_w;
                hold_full_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            empty_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            empty_q     <= empty_d;
            ovf_q       <= ovf_d;
        end
    end

    assign empty_frame = empty_q;
    assign overflow    = ovf_q;

`ifdef SPARSE_DECODER_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d, pop_cnt;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < SIZE; i++)
            pop_cnt = pop_cnt + CNT_W'(frame_w[i]);
    end

    // Held with the frame; zero once its last address drains.
    always_comb begin
        count_d = count_q;
        if (load)             count_d = pop_cnt;
        else if (!hold_full_d) count_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign frame_count = count_q;
`else
    logic unused_load;
    assign unused_load = load;
`endif

endmodule
